apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB4 master port between NoMasters independent requesters, e.g. several axi_lite_to_apb bridges or debug/DMA agents driving one peripheral segment.
- Round-robin arbitration per transfer.
- Sequences the APB SETUP/ACCESS phases.
- Returns read data and error to the granted requester.
- Adds a PREADY timeout so a hung slave cannot lock the bus.

Parameters:
- NoMasters, 2, number of requesters (>=1).
- AddrWidth, 32, PADDR width.
- DataWidth, 32, PWDATA/PRDATA width (multiple of 8).
- TimeoutCycles, 256, ACCESS cycles without PREADY before forced error completion; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NoMasters  per-requester transfer request.
- req_ready_o  out  NoMasters  one-hot grant/accept pulse.
- req_addr_i  in  NoMasters*AddrWidth  address per requester.
- req_write_i  in  NoMasters  1 = write.
- req_wdata_i  in  NoMasters*DataWidth  write data.
- req_strb_i  in  NoMasters*DataWidth/8  byte strobes.
- req_prot_i  in  NoMasters*3  PPROT.
- rsp_valid_o  out  NoMasters  one-hot completion pulse (no backpressure).
- rsp_rdata_o  out  DataWidth  read data, shared by all requesters, valid with rsp_valid_o.
- rsp_err_o  out  1  PSLVERR or timeout, valid with rsp_valid_o.
- paddr_o  out  AddrWidth  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB write.
- pwdata_o  out  DataWidth  APB write data.
- pstrb_o  out  DataWidth/8  APB strobes (0 on reads).
- pprot_o  out  3  APB protection.
- pready_i  in  1  APB ready.
- prdata_i  in  DataWidth  APB read data.
- pslverr_i  in  1  APB error.

Behaviour:
- Reset values (asynchronous on rst_i):
  - All outputs 0, state IDLE.
  - RR pointer 0, timeout counter 0.
- States: IDLE, SETUP, ACCESS.
- Request handshake: a requester holds valid and payload stable until its req_ready_o pulse; it may not deassert valid before that pulse.
- IDLE:
  - If any req_valid_i is set, pick the winner by round robin from the pointer.
  - Pulse req_ready_o[winner] combinationally in that same cycle.
  - Capture the winner's payload and index into registers.
  - Advance the pointer to (winner+1) mod NoMasters.
  - Go to SETUP.
  - With no request, stay in IDLE; the pointer does not move.
- SETUP: psel=1, penable=0, registered payload driven; go to ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1, payload held stable.
  - On pready_i=1:
    - Latch prdata_i (reads only; writes return rdata 0) and pslverr_i.
    - Next cycle, pulse rsp_valid_o[idx] for exactly one cycle.
    - Go to IDLE.
- Timeout:
  - The counter increments on each ACCESS cycle with pready_i=0.
  - At count == TimeoutCycles-1 with pready_i still 0: complete as if pready with err=1, rdata=0, and drop psel/penable.
  - The counter clears on entering SETUP.
- Timing:
  - Minimum latency from accept to rsp_valid_o is 3 cycles (accept, SETUP, ACCESS with pready, then rsp).
  - psel_o is low for at least one cycle (the IDLE accept cycle) between consecutive transfers.
  - A new accept may coincide with the rsp_valid_o cycle of the previous transfer.
- pwdata_o and pstrb_o are zero-forced on reads.
- paddr/pwrite/pprot stay constant from SETUP until completion.
- Simultaneous requests: exactly one grant per accept cycle. The others stay pending, and a continuously requesting master is served within NoMasters transfers.
- Requests arriving during SETUP/ACCESS are not accepted: req_ready_o is 0 outside IDLE.
- NoMasters=1: the arbiter degenerates to a fixed grant.
- Reset mid-transfer:
  - psel/penable drop immediately (asynchronous).
  - No rsp_valid_o is issued for the aborted transfer.

Decomposition:
- Package apb_arb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - localparam StrbWidth = DataWidth/8;
  - a helper function for counter width, $clog2(TimeoutCycles+1), minimum 1.
- One sub-module, apb_rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and winner index.
  - Instantiated once; the pointer register lives in the parent.

Test Plan:
- Single read: requester 0, addr 0x1000, slave pready on first ACCESS cycle, prdata 0xDEADBEEF -> psel rises at cycle 1, penable at cycle 2, rsp_valid_o=01 at cycle 3, rdata 0xDEADBEEF, err 0.
- Write with 2 wait states: requester 1 writes 0xA5A5A5A5, strb 0xF to 0x2004, pready low for 2 ACCESS cycles -> payload stable for 4 psel cycles, pstrb 0xF, rsp_valid_o=10 one cycle after pready, err 0.
- Contention: both requesters valid continuously for 4 transfers from reset -> grants in order 0,1,0,1, psel low one cycle between transfers.
- Slave error: pslverr=1 with pready on a read -> rsp_err_o=1 for the granted master only, rdata equals prdata.
- Timeout: TimeoutCycles=8, pready never asserted -> completion after 8 ACCESS cycles with err=1, rdata=0, then the next pending request is accepted.
- Reset mid-ACCESS: assert rst_i during ACCESS -> psel/penable/req_ready_o/rsp_valid_o go 0 in the same cycle with no response; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// apb_arb_pkg: shared types and helpers for the APB master arbiter.
//   state_e    - transfer sequencer states (IDLE / SETUP / ACCESS)
//   StrbWidth  - byte-strobe width for the default 32-bit data path
//   strb_width - strobe width for an arbitrary data width
//   cnt_width  - timeout counter width, never below 1 bit
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int DefDataWidth = 32;
  localparam int StrbWidth    = DefDataWidth / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_pick.sv
// apb_rr_pick: combinational round-robin picker.
//   req_i - request vector
//   ptr_i - highest-priority index for this pick
//   gnt_o - one-hot grant (zero when no request)
//   idx_o - index of the granted requester
module apb_rr_pick #(
  parameter int NoMasters = 2,
  parameter int IdxW      = 1
) (
  input  logic [NoMasters-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [NoMasters-1:0] gnt_o,
  output logic [IdxW-1:0]      idx_o
);

  // Walk from the farthest candidate back to the pointer so that the
  // requester closest to the pointer overwrites any earlier hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NoMasters - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NoMasters]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % NoMasters] = 1'b1;
        idx_o = IdxW'((int'(ptr_i) + k) % NoMasters);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB4 master port between NoMasters
// requesters with per-transfer round-robin arbitration and a PREADY timeout.
//   req_*    - per-requester flat request buses, accepted by a req_ready_o pulse
//   rsp_*    - one-hot completion pulse plus shared read data / error
//   p*       - APB4 master port
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NoMasters     = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NoMasters-1:0]              req_valid_i,
  output logic [NoMasters-1:0]              req_ready_o,
  input  logic [NoMasters*AddrWidth-1:0]    req_addr_i,
  input  logic [NoMasters-1:0]              req_write_i,
  input  logic [NoMasters*DataWidth-1:0]    req_wdata_i,
  input  logic [NoMasters*DataWidth/8-1:0]  req_strb_i,
  input  logic [NoMasters*3-1:0]            req_prot_i,
  output logic [NoMasters-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]              rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic [AddrWidth-1:0]              paddr_o,
  output logic                              psel_o,
  output logic                              penable_o,
  output logic                              pwrite_o,
  output logic [DataWidth-1:0]              pwdata_o,
  output logic [DataWidth/8-1:0]            pstrb_o,
  output logic [2:0]                        pprot_o,
  input  logic                              pready_i,
  input  logic [DataWidth-1:0]              prdata_i,
  input  logic                              pslverr_i
);

  localparam int StrbW  = strb_width(DataWidth);
  localparam int IdxW   = (NoMasters > 1) ? $clog2(NoMasters) : 1;
  localparam int CntW   = cnt_width(TimeoutCycles);
  localparam int ToLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic [NoMasters-1:0]  win_gnt, rsp_valid_q, rsp_valid_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [StrbW-1:0]      strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  timeout;

  apb_rr_pick #(.NoMasters(NoMasters), .IdxW(IdxW)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign timeout = (TimeoutCycles != 0) && (cnt_q == CntW'(ToLast));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    prot_d      = prot_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          idx_d   = win_idx;
          addr_d  = req_addr_i[win_idx*AddrWidth +: AddrWidth];
          write_d = req_write_i[win_idx];
          wdata_d = req_wdata_i[win_idx*DataWidth +: DataWidth];
          strb_d  = req_strb_i[win_idx*StrbW +: StrbW];
          prot_d  = req_prot_i[win_idx*3 +: 3];
          ptr_d   = (win_idx == IdxW'(NoMasters - 1)) ? '0 : win_idx + IdxW'(1);
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          rdata_d            = write_q ? '0 : prdata_i;
          err_d              = pslverr_i;
          rsp_valid_d[idx_q] = 1'b1;
          state_d            = IDLE;
        end else if (timeout) begin
          // Hung slave: finish the transfer with an error so the bus frees up.
          rdata_d            = '0;
          err_d              = 1'b1;
          rsp_valid_d[idx_q] = 1'b1;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      prot_q      <= prot_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Grant is combinational off IDLE; masked by reset so nothing is accepted
  // while the block is held in reset.
  assign req_ready_o = (state_q == IDLE && !rst_i) ? win_gnt : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = write_q ? wdata_q : '0;
  assign pstrb_o     = write_q ? strb_q : '0;
  assign pprot_o     = prot_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (2 requesters, 32-bit, timeout 8).
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_apb_master_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.NoMasters(2), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .req_prot_i(req_prot), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .paddr_o(paddr), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    checks++;
    if ((penable & ~psel) !== 1'b0) begin
      errors++;
      $error("FAIL mon_penable_wo_psel");
    end
    checks++;
    if (psel && (req_ready !== 2'b00)) begin
      errors++;
      $error("FAIL mon_ready_busy %0b", req_ready);
    end
    checks++;
    if ((rsp_valid & (rsp_valid - 2'b01)) !== 2'b00) begin
      errors++;
      $error("FAIL mon_rsp_onehot %0b", rsp_valid);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(posedge clk_i);
    smp;
    `CHK("rst_psel", psel, 1'b0);
    `CHK("rst_penable", penable, 1'b0);
    `CHK("rst_ready", req_ready, 2'b00);
    `CHK("rst_rsp", rsp_valid, 2'b00);
    `CHK("rst_rdata", rsp_rdata, 32'h0);
    `CHK("rst_err", rsp_err, 1'b0);
    `CHK("rst_paddr", paddr, 32'h0);
    rst_i = 1'b0;

    adv; req_valid = 2'b01; req_addr[31:0] = 32'h1000; req_prot[2:0] = 3'b010; smp;
    `CHK("rd_ready", req_ready, 2'b01);
    `CHK("rd_psel_c0", psel, 1'b0);
    adv; req_valid = 2'b00; smp;
    `CHK("rd_setup", {psel, penable}, 2'b10);
    `CHK("rd_paddr", paddr, 32'h1000);
    `CHK("rd_pprot", pprot, 3'b010);
    `CHK("rd_pstrb", pstrb, 4'h0);
    `CHK("rd_ready_setup", req_ready, 2'b00);
    adv; pready = 1'b1; prdata = 32'hDEADBEEF; smp;
    `CHK("rd_access", {psel, penable}, 2'b11);
    `CHK("rd_rsp_early", rsp_valid, 2'b00);
    adv; pready = 1'b0; prdata = '0; smp;
    `CHK("rd_rsp", rsp_valid, 2'b01);
    `CHK("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    `CHK("rd_err", rsp_err, 1'b0);
    `CHK("rd_psel_done", psel, 1'b0);
    adv; smp;
    `CHK("rd_rsp_pulse", rsp_valid, 2'b00);

    adv; req_valid = 2'b10; req_addr[63:32] = 32'h2004; req_write = 2'b10;
    req_wdata[63:32] = 32'hA5A5A5A5; req_strb[7:4] = 4'hF; smp;
    `CHK("wr_ready", req_ready, 2'b10);
    adv; req_valid = 2'b00; smp;
    `CHK("wr_setup", {psel, penable}, 2'b10);
    `CHK("wr_paddr", paddr, 32'h2004);
    `CHK("wr_pwrite", pwrite, 1'b1);
    `CHK("wr_pwdata", pwdata, 32'hA5A5A5A5);
    `CHK("wr_pstrb", pstrb, 4'hF);
    for (int i = 0; i < 2; i++) begin
      adv; smp;
      `CHK("wr_wait", {psel, penable}, 2'b11);
      `CHK("wr_wait_addr", paddr, 32'h2004);
      `CHK("wr_wait_data", pwdata, 32'hA5A5A5A5);
    end
    adv; pready = 1'b1; smp;
    `CHK("wr_last", {psel, penable}, 2'b11);
    `CHK("wr_last_strb", pstrb, 4'hF);
    `CHK("wr_rsp_early", rsp_valid, 2'b00);
    adv; pready = 1'b0; smp;
    `CHK("wr_rsp", rsp_valid, 2'b10);
    `CHK("wr_err", rsp_err, 1'b0);
    `CHK("wr_rdata", rsp_rdata, 32'h0);
    `CHK("wr_psel_done", psel, 1'b0);

    adv; rst_i = 1'b1; smp; rst_i = 1'b0;
    adv; req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h200, 32'h100};
    pready = 1'b1; prdata = 32'h11111111; smp;
    `CHK("ct_gnt0", req_ready, 2'b01);
    `CHK("ct_psel0", psel, 1'b0);
    for (int t = 0; t < 4; t++) begin
      adv; if (t == 3) req_valid = 2'b00; smp;
      `CHK("ct_addr", paddr, (t % 2 == 0) ? 32'h100 : 32'h200);
      `CHK("ct_ready_setup", req_ready, 2'b00);
      adv; smp;
      `CHK("ct_penable", penable, 1'b1);
      adv; smp;
      `CHK("ct_rsp", rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      `CHK("ct_psel_gap", psel, 1'b0);
      if (t < 3) `CHK("ct_gnt", req_ready, (t % 2 == 0) ? 2'b10 : 2'b01);
    end

    adv; pready = 1'b0; req_valid = 2'b10; req_addr[63:32] = 32'h3000; smp;
    `CHK("se_ready", req_ready, 2'b10);
    adv; req_valid = 2'b00; smp;
    adv; pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D; smp;
    adv; pready = 1'b0; pslverr = 1'b0; prdata = '0; smp;
    `CHK("se_rsp", rsp_valid, 2'b10);
    `CHK("se_err", rsp_err, 1'b1);
    `CHK("se_rdata", rsp_rdata, 32'hCAFEF00D);

    adv; req_valid = 2'b11; req_addr = {32'h4000, 32'h5000}; req_write = 2'b00;
    req_wdata[63:32] = 32'hFFFF0000; req_strb[7:4] = 4'hF; prdata = 32'hFFFFFFFF; smp;
    `CHK("to_ready", req_ready, 2'b01);
    adv; req_valid = 2'b10; smp;
    `CHK("to_addr", paddr, 32'h5000);
    for (int i = 0; i < 8; i++) begin
      adv; smp;
      `CHK("to_access", {psel, penable}, 2'b11);
      `CHK("to_rsp_early", rsp_valid, 2'b00);
    end
    adv; smp;
    `CHK("to_rsp", rsp_valid, 2'b01);
    `CHK("to_err", rsp_err, 1'b1);
    `CHK("to_rdata", rsp_rdata, 32'h0);
    `CHK("to_psel", psel, 1'b0);
    `CHK("to_next_gnt", req_ready, 2'b10);
    adv; req_valid = 2'b00; smp;
    `CHK("to2_addr", paddr, 32'h4000);
    `CHK("to2_pwdata_rd", pwdata, 32'h0);
    `CHK("to2_pstrb_rd", pstrb, 4'h0);
    `CHK("to2_pwrite", pwrite, 1'b0);
    adv; pready = 1'b1; prdata = 32'h12345678; smp;
    adv; pready = 1'b0; smp;
    `CHK("to2_rsp", rsp_valid, 2'b10);
    `CHK("to2_err", rsp_err, 1'b0);
    `CHK("to2_rdata", rsp_rdata, 32'h12345678);

    adv; req_valid = 2'b10; req_addr[63:32] = 32'h6000; smp;
    `CHK("mr_ready", req_ready, 2'b10);
    adv; req_valid = 2'b00; smp;
    adv; smp;
    `CHK("mr_access", {psel, penable}, 2'b11);
    #1 rst_i = 1'b1; req_valid = 2'b11;
    #1;
    `CHK("mr_bus_drop", {psel, penable}, 2'b00);
    `CHK("mr_ready_rst", req_ready, 2'b00);
    `CHK("mr_rsp_rst", rsp_valid, 2'b00);
    adv; pready = 1'b1; smp;
    `CHK("mr_rsp_hold", rsp_valid, 2'b00);
    `CHK("mr_psel_hold", psel, 1'b0);
    rst_i = 1'b0; pready = 1'b0;
    #1;
    `CHK("mr_first_gnt", req_ready, 2'b01);
    adv; req_valid = 2'b00; smp;
    `CHK("mr_no_rsp", rsp_valid, 2'b00);
    `CHK("mr_setup", psel, 1'b1);
    `CHK("mr_setup_addr", paddr, 32'h5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
